// File: rtl/wireout_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : wireout_sequencer
// Purpose  : Upload-path controller for the MCU wire interface. When the
//            wire-input FSM sits in WireOUT (wire_state==3) one frame is
//            streamed to the host over a valid/ready word link: echo header
//            16'hB79E, NUM_WORDS status words read from the status bank and,
//            optionally, the inverted 16-bit sum of those words. A one-cycle
//            wireoutfinish pulse then releases the wire-input FSM. A stalled
//            host link is aborted after TIMEOUT_CYC stalled cycles.
// Ports    : clk_in        system clock
//            rst_n         synchronous active-low reset
//            wire_state    wire-input FSM state (3 = WireOUT)
//            rd_addr       status bank read address
//            rd_data       status bank data, one cycle after rd_addr
//            tx_data       upload word to host
//            tx_valid      tx_data valid
//            tx_ready      host accepts word (transfer = tx_valid & tx_ready)
//            wireoutfinish one-cycle pulse, frame done or timed out
//            busy          high whenever the sequencer is not idle
//            timeout_err   sticky timeout flag, cleared at next frame start
// Options  : CHECKSUM_EN   when defined, appends ~sum(words) to each frame
// Revision : 1.0  initial release
// ============================================================================
module wireout_sequencer #(
  parameter int NUM_WORDS   = 16,
  parameter int ADDR_W      = 5,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic [2:0]        wire_state,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [15:0]       rd_data,
  output logic [15:0]       tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              wireoutfinish,
  output logic              busy,
  output logic              timeout_err
);

  localparam logic [15:0]       c_HEADER   = 16'hB79E;
  localparam logic [2:0]        c_WIREOUT  = 3'd3;
  localparam logic [ADDR_W-1:0] c_LAST_IDX = ADDR_W'(NUM_WORDS - 1);
  localparam logic [ADDR_W-1:0] c_IDX_ONE  = ADDR_W'(1);
  localparam int                c_STALL_W  = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [c_STALL_W-1:0] c_STALL_MAX = c_STALL_W'(TIMEOUT_CYC - 1);
  localparam logic [c_STALL_W-1:0] c_STALL_ONE = c_STALL_W'(1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_HDR       = 3'd1,
    S_FETCH     = 3'd2,
    S_SEND      = 3'd3,
    S_CSUM      = 3'd4,
    S_DONE      = 3'd5,
    S_WAIT_EXIT = 3'd6
  } state_t;

  state_t                r_state;
  logic [ADDR_W-1:0]     r_rd_addr;
  logic [ADDR_W-1:0]     r_idx;
  logic [15:0]           r_tx_data;
  logic                  r_tx_valid;
  logic                  r_finish;
  logic                  r_timeout_err;
  logic                  r_fetch_ph;
  logic [c_STALL_W-1:0]  r_stall_cnt;

  logic w_in_frame;
  logic w_xfer;
  logic w_stalled;
  logic w_timeout;

  assign w_in_frame = (wire_state == c_WIREOUT);
  assign w_xfer     = r_tx_valid & tx_ready;
  assign w_stalled  = r_tx_valid & ~tx_ready;
  // A transfer on the limit edge is not a stall, so the transfer wins.
  assign w_timeout  = w_stalled && (r_stall_cnt == c_STALL_MAX);

`ifdef CHECKSUM_EN
  logic [15:0] r_csum;
  logic [15:0] w_csum_next;
  assign w_csum_next = r_csum + r_tx_data;
`endif

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_rd_addr     <= '0;
      r_idx         <= '0;
      r_tx_data     <= '0;
      r_tx_valid    <= 1'b0;
      r_finish      <= 1'b0;
      r_timeout_err <= 1'b0;
      r_fetch_ph    <= 1'b0;
      r_stall_cnt   <= '0;
`ifdef CHECKSUM_EN
      r_csum        <= '0;
`endif
    end else begin
      r_finish <= 1'b0;

      if (w_stalled && !w_timeout) r_stall_cnt <= r_stall_cnt + c_STALL_ONE;
      else                         r_stall_cnt <= '0;

      case (r_state)
        S_IDLE: begin
          if (w_in_frame) begin
            r_state       <= S_HDR;
            r_tx_data     <= c_HEADER;
            r_tx_valid    <= 1'b1;
            r_timeout_err <= 1'b0;
            r_idx         <= '0;
`ifdef CHECKSUM_EN
            r_csum        <= '0;
`endif
          end
        end

        S_HDR: begin
          if (!w_in_frame) begin
            r_tx_valid <= 1'b0;
            r_state    <= S_IDLE;
          end else if (w_xfer) begin
            r_tx_valid <= 1'b0;
            r_rd_addr  <= '0;
            r_fetch_ph <= 1'b0;
            r_state    <= S_FETCH;
          end else if (w_timeout) begin
            r_tx_valid    <= 1'b0;
            r_timeout_err <= 1'b1;
            r_finish      <= 1'b1;
            r_state       <= S_DONE;
          end
        end

        // Phase 0 waits for the bank's one-cycle read latency; phase 1
        // captures the word.
        S_FETCH: begin
          if (!w_in_frame) begin
            r_state <= S_IDLE;
          end else if (r_fetch_ph) begin
            r_tx_data  <= rd_data;
            r_tx_valid <= 1'b1;
            r_state    <= S_SEND;
          end else begin
            r_fetch_ph <= 1'b1;
          end
        end

        S_SEND: begin
          if (!w_in_frame) begin
            r_tx_valid <= 1'b0;
            r_state    <= S_IDLE;
          end else if (w_xfer) begin
            if (r_idx == c_LAST_IDX) begin
`ifdef CHECKSUM_EN
              // Checksum word follows immediately, valid stays high.
              r_csum    <= w_csum_next;
              r_tx_data <= ~w_csum_next;
              r_state   <= S_CSUM;
`else
              r_tx_valid <= 1'b0;
              r_finish   <= 1'b1;
              r_state    <= S_DONE;
`endif
            end else begin
`ifdef CHECKSUM_EN
              r_csum     <= w_csum_next;
`endif
              r_tx_valid <= 1'b0;
              r_idx      <= r_idx + c_IDX_ONE;
              r_rd_addr  <= r_idx + c_IDX_ONE;
              r_fetch_ph <= 1'b0;
              r_state    <= S_FETCH;
            end
          end else if (w_timeout) begin
            r_tx_valid    <= 1'b0;
            r_timeout_err <= 1'b1;
            r_finish      <= 1'b1;
            r_state       <= S_DONE;
          end
        end

`ifdef CHECKSUM_EN
        S_CSUM: begin
          if (!w_in_frame) begin
            r_tx_valid <= 1'b0;
            r_state    <= S_IDLE;
          end else if (w_xfer) begin
            r_tx_valid <= 1'b0;
            r_finish   <= 1'b1;
            r_state    <= S_DONE;
          end else if (w_timeout) begin
            r_tx_valid    <= 1'b0;
            r_timeout_err <= 1'b1;
            r_finish      <= 1'b1;
            r_state       <= S_DONE;
          end
        end
`endif

        S_DONE: begin
          r_state <= S_WAIT_EXIT;
        end

        // Holding here until WireOUT is left limits the block to one
        // frame per WireOUT entry.
        S_WAIT_EXIT: begin
          if (!w_in_frame) r_state <= S_IDLE;
        end

        default: begin
          r_tx_valid <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

  assign rd_addr       = r_rd_addr;
  assign tx_data       = r_tx_data;
  assign tx_valid      = r_tx_valid;
  assign wireoutfinish = r_finish;
  assign timeout_err   = r_timeout_err;
  assign busy          = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: doc/wireout_sequencer.md
Name: wireout_sequencer

Overview:
Controller for the host upload path of the MCU wire interface. When the wire-input state machine enters its WireOUT state (upload header 16'hB79E received), this block streams a frame back to the host over a valid/ready word link:
- an echo header;
- NUM_WORDS status words read from the status register bank;
- an optional checksum.

It then pulses wireoutfinish so the wire-input state machine moves on to FINISH. A stalled host link is bounded by a timeout, so the wire-input side can never hang.

Parameters:
NUM_WORDS, 16, number of status words per frame (1..31)
ADDR_W, 5, width of rd_addr; must satisfy 2^ADDR_W >= NUM_WORDS
TIMEOUT_CYC, 4096, consecutive stalled cycles (tx_valid=1, tx_ready=0) before abort

Ports:
clk_in  input  1  system clock
rst_n  input  1  reset, synchronous, active-low
wire_state  input  3  state of wire-input FSM (0 IDLE, 1 SAVE, 2 FINISH, 3 WireOUT)
rd_addr  output  ADDR_W  status bank read address
rd_data  input  16  status bank data, valid 1 cycle after rd_addr changes
tx_data  output  16  upload word to host
tx_valid  output  1  tx_data valid
tx_ready  input  1  host accepts word; transfer = tx_valid & tx_ready at rising edge
wireoutfinish  output  1  one-cycle pulse, frame done or aborted by timeout
busy  output  1  high in any state other than IDLE
timeout_err  output  1  sticky; set on timeout abort, cleared at next frame start

Behaviour:
- Reset (rst_n=0 at a rising edge, any state, including mid-frame):
  - state=IDLE;
  - rd_addr=0, tx_data=0, tx_valid=0, wireoutfinish=0, busy=0, timeout_err=0;
  - word index, stall counter and checksum accumulator all cleared.
- FSM states: IDLE, HDR, FETCH, SEND, CSUM, DONE, WAIT_EXIT.
- IDLE:
  - When wire_state==3: next state HDR; tx_data<=16'hB79E, tx_valid<=1, timeout_err<=0, index<=0, checksum<=0.
  - First header word is therefore valid 1 cycle after wire_state reaches 3.
- HDR:
  - Hold tx_data/tx_valid until transfer.
  - On transfer: tx_valid<=0, rd_addr<=0, go FETCH.
- FETCH:
  - Lasts exactly 2 cycles; tx_valid=0 throughout.
  - On the second edge: tx_data<=rd_data, tx_valid<=1, go SEND.
- SEND:
  - Hold until transfer.
  - On transfer: checksum<=checksum+tx_data (16-bit, wrap mod 2^16), tx_valid<=0.
  - If index==NUM_WORDS-1: go CSUM (if checksum compiled in) else DONE.
  - Otherwise: index<=index+1, rd_addr<=index+1, go FETCH.
- CSUM (only with CHECKSUM_EN):
  - On entry: tx_data=~checksum (sum of all data words, header excluded), tx_valid=1.
  - On transfer: go DONE.
- DONE: wireoutfinish=1 for exactly this one cycle; tx_valid=0; go WAIT_EXIT.
- WAIT_EXIT:
  - Stay while wire_state==3; go IDLE when wire_state!=3.
  - Guarantees exactly one frame per WireOUT entry.
- Steady-state throughput: 3 cycles per data word with tx_ready held high.
- Stall timeout:
  - Stall counter increments each cycle with tx_valid=1 & tx_ready=0; clears on transfer or when tx_valid=0.
  - When the counter reaches TIMEOUT_CYC-1 while still stalled: tx_valid<=0, timeout_err<=1, go DONE (finish still pulses).
- Early exit: if wire_state leaves 3 in HDR/FETCH/SEND/CSUM, abort to IDLE next edge: tx_valid<=0, no wireoutfinish, timeout_err unchanged.
- Simultaneous events:
  - Transfer on the same edge the timeout limit is reached: the transfer wins; no timeout.
  - Reset has priority over everything.
- tx_data is not modified while tx_valid=1 and tx_ready=0.

Optional Feature:
CHECKSUM_EN:
- Defined: the CSUM state is compiled in; frame = header + NUM_WORDS words + ~sum.
- Undefined: CSUM is removed; SEND goes directly to DONE; the checksum accumulator is not instantiated.

Test Plan:
- NUM_WORDS=4, bank={0x0001,0x0002,0x0003,0x0004}, tx_ready=1, wire_state->3 -> words B79E,0001,0002,0003,0004,FFF5 (CHECKSUM_EN); wireoutfinish pulses 1 cycle; busy returns to 0 after wire_state->2.
- Same stimulus, tx_ready toggling 1/0 every cycle -> identical word sequence, tx_data stable during every stall, no duplicates or drops.
- tx_ready held 0 after header accepted, TIMEOUT_CYC=16 -> tx_valid drops after 16 stalled cycles, timeout_err=1, wireoutfinish pulses; next frame start clears timeout_err.
- rst_n=0 for 1 cycle while in SEND at index 2 -> next cycle all outputs 0, state IDLE; with wire_state still 3, a new frame starts with header B79E.
- wire_state held at 3 for 200 cycles after DONE -> exactly one frame and one wireoutfinish pulse; wire_state 3->0 in FETCH -> tx_valid stays 0, no wireoutfinish.
- Bank words 0xFFFF,0x0002 (NUM_WORDS=2) -> checksum word ~0x0001 = 0xFFFE (wrap-around check).
